// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding, opcodes, width helper.
// Latency: n/a (package).
// Backpressure: n/a (package).
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Bits needed to count 0..v-1; never less than 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// Purely combinational 1-bit full adder: sum and carry-out of A, B and carry-in C0.
// Latency: zero cycles.
// Backpressure: none; the cell has no state.
module fa_cell (
  input  logic A,
  input  logic B,
  input  logic C0,
  output logic F,
  output logic C1
);

  assign F  = A ^ B ^ C0;
  assign C1 = (A & B) | (A & C0) | (B & C0);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit add/subtract, LSB first, one full-adder cell and a carry flop.
// Latency: DONE pulses WIDTH+1 cycles after the START cycle; one result per WIDTH+2 cycles.
// Backpressure: START is sampled only in IDLE; requests while BUSY are dropped, not queued.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] F,
  output logic             C1,
  output logic             OVF
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_MSB  = CW'(WIDTH - 2);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             cin_msb;
  logic             s;
  logic             co;

  fa_cell u_fa (
    .A  (ra[0]),
    .B  (rb[0]),
    .C0 (carry),
    .F  (s),
    .C1 (co)
  );

  // Result bit for this cycle lands at position cnt; the final value feeds F directly.
  always_comb begin
    acc_nxt      = acc;
    acc_nxt[cnt] = s;
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    case (state)
      ST_IDLE: if (START) state_nxt = ST_RUN;
      ST_RUN: begin
        BUSY = 1'b1;
        if (cnt == CNT_LAST) state_nxt = ST_FIN;
      end
      ST_FIN: begin
        BUSY      = 1'b1;
        DONE      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand load, serial shift, and result capture on the last RUN cycle.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ra      <= '0;
      rb      <= '0;
      acc     <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      cin_msb <= 1'b0;
      F       <= '0;
      C1      <= 1'b0;
      OVF     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            // Subtract is A + ~B + 1: invert B and seed the carry.
            ra    <= A;
            rb    <= (SUB == OP_ADD) ? B : ~B;
            carry <= (SUB == OP_SUB);
            cnt   <= '0;
            acc   <= '0;
          end
        end
        ST_RUN: begin
          acc   <= acc_nxt;
          ra    <= ra >> 1;
          rb    <= rb >> 1;
          carry <= co;
          // Carry into the MSB, needed for the overflow test.
          if (cnt == CNT_MSB) cin_msb <= co;
          if (cnt == CNT_LAST) begin
            F   <= acc_nxt;
            C1  <= co;
            OVF <= cin_msb ^ co;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub (WIDTH=8): timing, arithmetic flags, ignore-while-busy, reset abort, back-to-back.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_serial_addsub;

  logic       CLK;
  logic       RST_N;
  logic       START;
  logic       SUB;
  logic [7:0] A;
  logic [7:0] B;
  logic       BUSY;
  logic       DONE;
  logic [7:0] F;
  logic       C1;
  logic       OVF;

  int n_checks = 0;
  int n_pass   = 0;

  serial_addsub #(.WIDTH(8)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .SUB   (SUB),
    .A     (A),
    .B     (B),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .F     (F),
    .C1    (C1),
    .OVF   (OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; all driving and sampling happens 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference arithmetic: returns {ovf, c1, f}.
  function automatic logic [9:0] model(input logic sub, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] r;
    logic       ovf;
    if (!sub) begin
      r   = {1'b0, a} + {1'b0, b};
      ovf = (a[7] == b[7]) && (r[7] != a[7]);
    end else begin
      r   = {1'b0, a} + {1'b0, ~b} + 9'd1;
      ovf = (a[7] != b[7]) && (r[7] != a[7]);
    end
    return {ovf, r[8], r[7:0]};
  endfunction

  // Issue one operation from IDLE and check its result; operands are scrambled after acceptance.
  task automatic run_op(input string tag, input logic sub, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ef, input logic ec, input logic eo, input bit timing);
    int n;
    int busy_n;
    START = 1'b1; SUB = sub; A = a; B = b;
    tick();
    START = 1'b0; SUB = ~sub; A = ~a; B = a ^ b;
    n = 1;
    busy_n = BUSY ? 1 : 0;
    while (!DONE && n < 20) begin
      tick();
      n++;
      if (BUSY) busy_n++;
    end
    check({tag, "_done"}, DONE, 1);
    if (timing) begin
      check({tag, "_latency"}, n, 9);
      check({tag, "_busy_cycles"}, busy_n, 9);
    end
    check({tag, "_f"}, F, ef);
    check({tag, "_c1"}, C1, ec);
    check({tag, "_ovf"}, OVF, eo);
    tick();
    check({tag, "_done_pulse"}, DONE, 0);
  endtask

  initial begin
    int         dones;
    int         idx;
    int         t;
    int         tdone[3];
    logic       prev_busy;
    logic [7:0] fcap;
    logic [9:0] m;
    logic [7:0] pa[3];
    logic [7:0] pb[3];
    logic       ps[3];

    RST_N = 1'b0; START = 1'b0; SUB = 1'b0; A = '0; B = '0;
    tick(); tick();
    RST_N = 1'b1;
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_f", F, 8'h00);
    check("rst_c1", C1, 0);
    check("rst_ovf", OVF, 0);

    // Basic add with latency and busy-length checks.
    run_op("add_3c_21", 1'b0, 8'h3C, 8'h21, 8'h5D, 1'b0, 1'b0, 1'b1);
    // Carry and overflow corners.
    run_op("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
    run_op("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
    run_op("sub_05_07", 1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b1);
    run_op("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0);

    // START pulsed in the middle of RUN must be ignored.
    START = 1'b1; SUB = 1'b0; A = 8'h10; B = 8'h10;
    tick();
    START = 1'b0;
    tick(); tick();
    START = 1'b1; SUB = 1'b1; A = 8'hFF; B = 8'hFF;
    tick();
    START = 1'b0;
    dones = 0;
    fcap  = '0;
    for (int i = 0; i < 15; i++) begin
      if (DONE) begin dones++; fcap = F; end
      tick();
    end
    check("busy_ignore_dones", dones, 1);
    check("busy_ignore_f", fcap, 8'h20);

    // Reset in the middle of a subtraction aborts it silently.
    START = 1'b1; SUB = 1'b1; A = 8'h20; B = 8'h03;
    tick();
    START = 1'b0;
    tick(); tick(); tick();
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    check("abort_busy", BUSY, 0);
    check("abort_done", DONE, 0);
    check("abort_f", F, 8'h00);
    check("abort_c1", C1, 0);
    check("abort_ovf", OVF, 0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (DONE) dones++;
    end
    check("abort_no_done", dones, 0);
    run_op("add_01_02", 1'b0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b1);

    // START held high: three operations back to back.
    pa[0] = 8'h11; pb[0] = 8'h22; ps[0] = 1'b0;
    pa[1] = 8'h40; pb[1] = 8'h50; ps[1] = 1'b1;
    pa[2] = 8'hC8; pb[2] = 8'h64; ps[2] = 1'b0;
    START = 1'b1; SUB = ps[0]; A = pa[0]; B = pb[0];
    idx = 0; dones = 0; prev_busy = BUSY;
    for (t = 0; t < 45; t++) begin
      tick();
      if (BUSY && !prev_busy) begin
        idx++;
        if (idx < 3) begin
          SUB = ps[idx]; A = pa[idx]; B = pb[idx];
        end else begin
          START = 1'b0;
        end
      end
      prev_busy = BUSY;
      if (DONE) begin
        if (dones < 3) begin
          m = model(ps[dones], pa[dones], pb[dones]);
          check($sformatf("b2b_f%0d", dones), F, m[7:0]);
          tdone[dones] = t;
        end
        dones++;
      end
    end
    START = 1'b0;
    check("b2b_dones", dones, 3);
    if (dones >= 3) begin
      check("b2b_gap01", tdone[1] - tdone[0], 10);
      check("b2b_gap12", tdone[2] - tdone[1], 10);
    end
    tick(); tick();

    // Strided sweep over operand space including 0x00, 0xFF and sign-boundary values.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        for (int s = 0; s < 2; s++) begin
          logic [7:0] a;
          logic [7:0] b;
          a = 8'(i * 17);
          b = 8'(j * 17 + 8);
          m = model(s[0], a, b);
          run_op($sformatf("sweep_%0s_%02h_%02h", s ? "sub" : "add", a, b),
                 s[0], a, b, m[7:0], m[8], m[9], 1'b0);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
